// File: rtl/layer1_asm_ctrl.sv
// ---------------------------------------------------------------------------
// layer1_asm_ctrl
//
// Sequencer for a first-layer array of ASM (accumulate/sign/majority) units.
// One run is:
//   1. load the batch-norm parameters once: walk the BN ROM address and, one
//      cycle later (ROM read latency), strobe asm_send for the matching ASM;
//   2. for every output window: accept kernel_len pixel/weight beats with
//      calculate_en, pulse asm_reception so the ASMs evaluate, capture their
//      outputs into out_data and hand that word downstream;
//   3. pulse done and return to idle.
//
// Ports
//   clk, rst          single clock, asynchronous active-high reset
//   start             one-cycle run request, honoured only while idle
//   num_windows       windows in the run, captured on an accepted start
//   bn_addr           BN parameter ROM address (ROM answers one cycle later)
//   asm_send          one-hot "latch data_bn" strobe per ASM
//   pix_valid/ready   upstream beat handshake
//   calculate_en      ASM accumulate enable, one cycle per accepted beat
//   asm_reception     "evaluate and present data_out" strobe to all ASMs
//   asm_data          ASM array outputs, bit k from ASM k
//   out_data/valid    captured window result, held until out_ready
//   out_ready         downstream accepts out_data
//   busy              high whenever the controller is not idle
//   done              one-cycle pulse at the end of a run
//   dbg_state_o       current FSM state, for debug and assertion binding
//
// Handshake rule (both pix_* and out_*): a transfer happens on a rising clock
// edge where valid and ready are both high; the producer keeps its payload
// stable while valid is high and ready is low.
// ---------------------------------------------------------------------------
module layer1_asm_ctrl #(
  parameter int asm_number = 8,
  parameter int kernel_len = 9,
  parameter int win_width  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [win_width-1:0]  num_windows,
  output logic [2:0]            bn_addr,
  output logic [asm_number-1:0] asm_send,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  output logic                  calculate_en,
  output logic [asm_number-1:0] asm_reception,
  input  logic [asm_number-1:0] asm_data,
  output logic [asm_number-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            dbg_state_o
);

  // BN counter runs 0..asm_number (one extra cycle for the ROM latency).
  localparam int BN_W   = $clog2(asm_number + 1);
  // Beat counter runs 0..kernel_len-1; the last beat leaves ACC directly.
  localparam int BEAT_W = (kernel_len > 1) ? $clog2(kernel_len) : 1;

  localparam logic [BN_W-1:0]       BN_LAST   = BN_W'(asm_number);
  localparam logic [BEAT_W-1:0]     BEAT_LAST = BEAT_W'(kernel_len - 1);
  localparam logic [asm_number-1:0] SEND_BIT0 = asm_number'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_BN = 3'd1,
    S_ACC     = 3'd2,
    S_RECV    = 3'd3,
    S_CAPT    = 3'd4,
    S_OUT     = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t                state_q, state_d;
  logic [BN_W-1:0]       bn_cnt_q, bn_cnt_d;
  logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [win_width-1:0]  win_cnt_q, win_cnt_d;
  logic [win_width-1:0]  num_win_q, num_win_d;
  logic [asm_number-1:0] out_data_q, out_data_d;

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bn_cnt_q   <= '0;
      beat_cnt_q <= '0;
      win_cnt_q  <= '0;
      num_win_q  <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      bn_cnt_q   <= bn_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      win_cnt_q  <= win_cnt_d;
      num_win_q  <= num_win_d;
      out_data_q <= out_data_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and output decode. All strobes are decoded from the current
  // state, so an asynchronous reset forces every one of them low at once.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    bn_cnt_d      = bn_cnt_q;
    beat_cnt_d    = beat_cnt_q;
    win_cnt_d     = win_cnt_q;
    num_win_d     = num_win_q;
    out_data_d    = out_data_q;
    bn_addr       = 3'd0;
    asm_send      = '0;
    pix_ready     = 1'b0;
    calculate_en  = 1'b0;
    asm_reception = '0;
    out_valid     = 1'b0;
    done          = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          num_win_d  = num_windows;
          bn_cnt_d   = '0;
          beat_cnt_d = '0;
          win_cnt_d  = '0;
          // An empty run still reports completion so the caller never waits.
          state_d    = (num_windows != '0) ? S_LOAD_BN : S_DONE;
        end
      end

      S_LOAD_BN: begin
        // Address i is presented in cycle i; the ROM word for ASM i arrives a
        // cycle later, which is when ASM i is told to latch it.
        if (bn_cnt_q < BN_LAST) begin
          bn_addr = 3'(bn_cnt_q);
        end
        if (bn_cnt_q != '0) begin
          asm_send = SEND_BIT0 << (bn_cnt_q - BN_W'(1));
        end
        if (bn_cnt_q == BN_LAST) begin
          state_d = S_ACC;
        end else begin
          bn_cnt_d = bn_cnt_q + BN_W'(1);
        end
      end

      S_ACC: begin
        pix_ready    = 1'b1;
        calculate_en = pix_valid;
        if (pix_valid) begin
          if (beat_cnt_q == BEAT_LAST) begin
            state_d = S_RECV;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end
      end

      S_RECV: begin
        asm_reception = '1;
        state_d       = S_CAPT;
      end

      S_CAPT: begin
        // The ASMs present data_out in the cycle after the reception strobe.
        out_data_d = asm_data;
        state_d    = S_OUT;
      end

      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (win_cnt_q < (num_win_q - win_width'(1))) begin
            // BN parameters stay loaded in the ASMs; only the beats restart.
            win_cnt_d  = win_cnt_q + win_width'(1);
            beat_cnt_d = '0;
            state_d    = S_ACC;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign out_data    = out_data_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_layer1_asm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_layer1_asm_ctrl
//
// Drives runs of the ASM controller and checks every cycle against a
// timeline model built from the run rules: BN load occupies cycles
// 1..asm_number+1 after start, each window needs kernel_len accepted beats,
// reception/capture/output follow the last beat by 1/2/3 cycles, and done
// follows the final output handshake by one cycle. Expected window results
// are kept in exp_q (the asm_data value seen in each capture cycle).
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_layer1_asm_ctrl;

  localparam int ASM_N  = 8;
  localparam int K      = 9;
  localparam int WW     = 16;
  localparam int BUDGET = 2000;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WW-1:0]    num_windows;
  logic [2:0]       bn_addr;
  logic [ASM_N-1:0] asm_send;
  logic             pix_valid;
  logic             pix_ready;
  logic             calculate_en;
  logic [ASM_N-1:0] asm_reception;
  logic [ASM_N-1:0] asm_data;
  logic [ASM_N-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic [2:0]       dbg_state_o;

  int checks   = 0;
  int failures = 0;

  logic [ASM_N-1:0] exp_q[$];
  logic [ASM_N-1:0] last_out;
  bit               fix_data_en;
  logic [ASM_N-1:0] fix_data;

  layer1_asm_ctrl #(
    .asm_number(ASM_N),
    .kernel_len(K),
    .win_width (WW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_windows  (num_windows),
    .bn_addr      (bn_addr),
    .asm_send     (asm_send),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .calculate_en (calculate_en),
    .asm_reception(asm_reception),
    .asm_data     (asm_data),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .done         (done),
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // One run. vmode: 0 valid held high, 1 toggling, 2 random.
  // stall_win/stall_len: hold out_ready low for stall_len cycles on that
  // window index. stray: random start pulses while busy. abort_beats>0
  // returns right after that many beats were accepted (for reset tests).
  // Entered and left 1 time unit after a rising edge.
  // ---------------------------------------------------------------------
  task automatic run_job(input int nw, input int vmode, input int stall_win,
                         input int stall_len, input bit rnd_ready,
                         input bit stray, input int abort_beats);
    int cyc, beats, wb, wins, stall_cnt;
    int cen_seen, recv_seen, done_seen;
    int acc_from, out_from, recv_at, capt_at, done_at;
    bit acc_on, out_on, finished;
    logic [ASM_N-1:0] exp_send, exp_recv;

    exp_q.delete();
    beats = 0; wb = 0; wins = 0; stall_cnt = 0;
    cen_seen = 0; recv_seen = 0; done_seen = 0;
    acc_from = (nw != 0) ? ASM_N + 2 : -1;
    out_from = -1; recv_at = -1; capt_at = -1;
    done_at  = (nw == 0) ? 1 : -1;
    acc_on = 1'b0; out_on = 1'b0; finished = 1'b0;

    // cycle 0: request in IDLE
    start       = 1'b1;
    num_windows = WW'(nw);
    pix_valid   = 1'b0;
    out_ready   = 1'b0;
    asm_data    = ASM_N'($urandom);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_busy got=%b exp=0", busy);
    end
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 1;

    while (!finished && cyc < BUDGET) begin
      if (cyc == acc_from) acc_on = 1'b1;
      if (cyc == out_from) out_on = 1'b1;

      case (vmode)
        0:       pix_valid = 1'b1;
        1:       pix_valid = (cyc % 2 == 0);
        default: pix_valid = 1'($urandom_range(0, 1));
      endcase
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_on && wins == stall_win && stall_cnt < stall_len) begin
        out_ready = 1'b0;
        stall_cnt++;
      end
      asm_data = fix_data_en ? fix_data : ASM_N'($urandom);
      if (stray && cyc >= 2) begin
        start       = 1'($urandom_range(0, 1));
        num_windows = WW'($urandom_range(0, 5));
      end

      @(negedge clk);
      exp_send = '0;
      if (nw != 0 && cyc >= 2 && cyc <= ASM_N + 1) exp_send = ASM_N'(1) << (cyc - 2);
      exp_recv = (cyc == recv_at) ? '1 : '0;

      checks++;
      if (asm_send !== exp_send) begin
        failures++;
        $display("FAIL asm_send cyc=%0d got=%h exp=%h", cyc, asm_send, exp_send);
      end
      checks++;
      if (asm_reception !== exp_recv) begin
        failures++;
        $display("FAIL asm_reception cyc=%0d got=%h exp=%h", cyc, asm_reception, exp_recv);
      end
      checks++;
      if (pix_ready !== acc_on) begin
        failures++;
        $display("FAIL pix_ready cyc=%0d got=%b exp=%b", cyc, pix_ready, acc_on);
      end
      checks++;
      if (calculate_en !== (acc_on & pix_valid)) begin
        failures++;
        $display("FAIL calculate_en cyc=%0d got=%b exp=%b", cyc, calculate_en, acc_on & pix_valid);
      end
      checks++;
      if (out_valid !== out_on) begin
        failures++;
        $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, out_on);
      end
      checks++;
      if (done !== (cyc == done_at)) begin
        failures++;
        $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, (cyc == done_at));
      end
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL busy cyc=%0d got=%b exp=1", cyc, busy);
      end
      if (nw != 0 && cyc <= ASM_N) begin
        checks++;
        if (bn_addr !== 3'(cyc - 1)) begin
          failures++;
          $display("FAIL bn_addr cyc=%0d got=%0d exp=%0d", cyc, bn_addr, cyc - 1);
        end
      end
      if (out_on) begin
        checks++;
        if (out_data !== exp_q[0]) begin
          failures++;
          $display("FAIL out_data cyc=%0d got=%h exp=%h", cyc, out_data, exp_q[0]);
        end
      end

      if (calculate_en === 1'b1) cen_seen++;
      if (asm_reception !== '0) recv_seen++;
      if (done === 1'b1) done_seen++;
      if (cyc == capt_at) exp_q.push_back(asm_data);

      // advance the timeline with this cycle's transfers
      if (acc_on && pix_valid) begin
        beats++;
        wb++;
        if (wb == K) begin
          acc_on   = 1'b0;
          recv_at  = cyc + 1;
          capt_at  = cyc + 2;
          out_from = cyc + 3;
        end
      end
      if (out_on && out_ready) begin
        last_out = exp_q.pop_front();
        out_on   = 1'b0;
        wins++;
        if (wins == nw) done_at = cyc + 1;
        else begin
          acc_from = cyc + 1;
          wb       = 0;
        end
      end
      if (cyc == done_at) finished = 1'b1;
      if (abort_beats > 0 && beats == abort_beats) finished = 1'b1;

      @(posedge clk); #1;
      cyc++;
    end

    if (!finished) begin
      checks++;
      failures++;
      $display("FAIL run_timeout nw=%0d got=%0d_cycles exp=finish", nw, cyc);
    end else if (abort_beats == 0) begin
      // one idle cycle after the run
      start     = 1'b0;
      pix_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL after_run busy/done got=%b%b exp=00", busy, done);
      end
      if (nw != 0) begin
        checks++;
        if (out_data !== last_out) begin
          failures++;
          $display("FAIL out_retain got=%h exp=%h", out_data, last_out);
        end
      end
      checks++;
      if (cen_seen != K * nw) begin
        failures++;
        $display("FAIL beat_total got=%0d exp=%0d", cen_seen, K * nw);
      end
      checks++;
      if (recv_seen != nw) begin
        failures++;
        $display("FAIL recv_total got=%0d exp=%0d", recv_seen, nw);
      end
      checks++;
      if (done_seen != 1) begin
        failures++;
        $display("FAIL done_total got=%0d exp=1", done_seen);
      end
      @(posedge clk); #1;
    end
  endtask

  // ------------------------------------------------------------ scenarios
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; num_windows = '0; pix_valid = 1'b0;
    out_ready = 1'b0; asm_data = '0; fix_data_en = 1'b0; fix_data = '0;
    last_out = '0;
    #12;
    checks++;
    if ({asm_send, asm_reception, out_data} !== '0 ||
        {bn_addr, pix_ready, calculate_en, out_valid, busy, done} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h_%h_%h_%b%b%b%b%b bn=%0d exp=all_zero",
               asm_send, asm_reception, out_data, pix_ready, calculate_en,
               out_valid, busy, done, bn_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || dbg_state_o !== 3'd0) begin
      failures++;
      $display("FAIL reset_release busy=%b state=%0d exp=0/0", busy, dbg_state_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_window();
    fix_data_en = 1'b1;
    fix_data    = 8'hA5;
    run_job(1, 0, -1, 0, 1'b0, 1'b0, 0);
    fix_data_en = 1'b0;
    checks++;
    if (out_data !== 8'hA5) begin
      failures++;
      $display("FAIL single_out_data got=%h exp=a5", out_data);
    end
  endtask

  task automatic test_gapped_valid();
    run_job(1, 1, -1, 0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    run_job(3, 0, 1, 5, 1'b0, 1'b0, 0);
  endtask

  task automatic test_zero_windows();
    run_job(0, 0, -1, 0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_reset_mid_acc();
    run_job(1, 0, -1, 0, 1'b0, 1'b0, 4);
    rst = 1'b1;
    #1;
    checks++;
    if ({asm_send, asm_reception, out_data} !== '0 ||
        {bn_addr, pix_ready, calculate_en, out_valid, busy, done} !== '0) begin
      failures++;
      $display("FAIL mid_acc_reset got=%h_%h_%h_%b%b%b%b%b exp=all_zero",
               asm_send, asm_reception, out_data, pix_ready, calculate_en,
               out_valid, busy, done);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst       = 1'b0;
    pix_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (asm_send !== '0 || asm_reception !== '0 || calculate_en !== 1'b0 ||
          done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL post_reset_quiet i=%0d got=%h_%h_%b%b%b exp=quiet",
                 i, asm_send, asm_reception, calculate_en, done, busy);
      end
      @(posedge clk); #1;
    end
    // fresh run, with stray start pulses while busy that must be ignored
    run_job(1, 0, -1, 0, 1'b0, 1'b1, 0);
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 4; j++) begin
      run_job($urandom_range(1, 4), 2, $urandom_range(0, 2), $urandom_range(0, 6),
              1'b1, 1'b1, 0);
    end
  endtask

  initial begin
    test_reset();
    test_single_window();
    test_gapped_valid();
    test_backpressure();
    test_zero_windows();
    test_reset_mid_acc();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
